// File: rtl/mega_jsoc_oci_dct_pkg.sv
// Shared definitions for the OCI data-capture-trace producer and sink:
// geometry, FSM encoding, fragment length codes and symbol masking.
package mega_jsoc_oci_dct_pkg;

    localparam int SLOT_W     = 2;
    localparam int SLOTS      = 15;
    localparam int CNT_W      = 4;
    localparam int BUF_W      = SLOT_W * SLOTS;
    localparam int FRAG_SLOTS = 3;
    localparam int FRAG_W     = SLOT_W * FRAG_SLOTS;
    localparam int SUM_W      = 5;

    typedef enum logic [1:0] {
        ST_PACK  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ENDED = 2'd3
    } dct_state_e;

    localparam logic [1:0] FRAG_LEN_NONE = 2'd0;
    localparam logic [1:0] FRAG_LEN_1    = 2'd1;
    localparam logic [1:0] FRAG_LEN_2    = 2'd2;
    localparam logic [1:0] FRAG_LEN_3    = 2'd3;

    // Zero the symbols beyond len so OR-merging never pollutes unused slots.
    function automatic logic [FRAG_W-1:0] frag_mask(input logic [FRAG_W-1:0] data,
                                                    input logic [1:0] len);
        logic [FRAG_W-1:0] m;
        case (len)
            FRAG_LEN_NONE: m = '0;
            FRAG_LEN_1:    m = {4'b0, data[1:0]};
            FRAG_LEN_2:    m = {2'b0, data[3:0]};
            default:       m = data;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mega_jsoc_oci_dct_out_reg.sv
// One-entry valid/ready holding register for packed DCT words.
// The caller only loads when out_free; a load may coincide with a drain.
module mega_jsoc_oci_dct_out_reg
    import mega_jsoc_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BUF_W-1:0] load_buf,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BUF_W-1:0] out_buf,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_free
);

    logic             valid_q, valid_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        out_free = !valid_q || out_ready;
        valid_d  = valid_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        if (load) begin
            valid_d = 1'b1;
            buf_d   = load_buf;
            cnt_d   = load_cnt;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_buf   = buf_q;
    assign out_cnt   = cnt_q;

endmodule

// File: rtl/mega_jsoc_cpu_oci_dct_packer.sv
// DCT producer: packs 2-bit trace symbols into 15-slot words, forces out stale
// partial words after an idle period, and sequences end-of-test.
module mega_jsoc_cpu_oci_dct_packer
    import mega_jsoc_oci_dct_pkg::*;
#(
    parameter int IDLE_FLUSH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frag_valid,
    output logic              frag_ready,
    input  logic [FRAG_W-1:0] frag_data,
    input  logic [1:0]        frag_len,
    input  logic              end_req,
    output logic              dct_valid,
    input  logic              dct_ready,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              test_ending,
    output logic              test_has_ended
);

    localparam logic [7:0]       IDLE_LAST = 8'(IDLE_FLUSH - 1);
    localparam logic [CNT_W-1:0] FILL_SAFE = CNT_W'(SLOTS - FRAG_SLOTS);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SLOTS);
    localparam logic [SUM_W-1:0] SUM_FULL  = SUM_W'(SLOTS);

    dct_state_e       state_q, state_d;
    logic [BUF_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [7:0]       idle_q, idle_d;
    logic             test_ending_q, test_has_ended_q;

    logic             out_free, load, accept;
    logic [BUF_W-1:0] ld_buf, frag_sh;
    logic [CNT_W-1:0] ld_cnt;
    logic [FRAG_W-1:0] frag_m;
    logic [SUM_W-1:0] sum;

    always_comb begin
        frag_ready = !reset && (state_q == ST_PACK) && (acc_cnt_q <= FILL_SAFE || out_free);
        accept     = frag_valid && frag_ready;
        frag_m     = frag_mask(frag_data, frag_len);
        frag_sh    = {{(BUF_W-FRAG_W){1'b0}}, frag_m} << {acc_cnt_q, 1'b0};
        sum        = SUM_W'(acc_cnt_q) + SUM_W'(frag_len);

        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        idle_d    = idle_q;
        load      = 1'b0;
        ld_buf    = acc_q;
        ld_cnt    = acc_cnt_q;

        if (accept) begin
            idle_d = '0;
            if (sum < SUM_FULL) begin
                acc_d     = acc_q | frag_sh;
                acc_cnt_d = sum[CNT_W-1:0];
            end else if (sum == SUM_FULL) begin
                // A full word with the output still busy stays in acc until it frees.
                if (out_free) begin
                    load      = 1'b1;
                    ld_buf    = acc_q | frag_sh;
                    ld_cnt    = CNT_FULL;
                    acc_d     = '0;
                    acc_cnt_d = '0;
                end else begin
                    acc_d     = acc_q | frag_sh;
                    acc_cnt_d = CNT_FULL;
                end
            end else begin
                load      = 1'b1;
                acc_d     = {{(BUF_W-FRAG_W){1'b0}}, frag_m};
                acc_cnt_d = CNT_W'(frag_len);
            end
        end else if (acc_cnt_q != '0 && out_free &&
                     (state_q == ST_FLUSH || acc_cnt_q == CNT_FULL ||
                      (state_q == ST_PACK && idle_q == IDLE_LAST))) begin
            load      = 1'b1;
            acc_d     = '0;
            acc_cnt_d = '0;
            idle_d    = '0;
        end else if (acc_cnt_q == '0 || state_q != ST_PACK) begin
            idle_d = '0;
        end else if (idle_q != IDLE_LAST) begin
            idle_d = idle_q + 8'd1;
        end

        state_d = state_q;
        case (state_q)
            ST_PACK:  if (end_req) state_d = ST_FLUSH;
            ST_FLUSH: if (acc_cnt_q == '0) state_d = ST_DRAIN;
            ST_DRAIN: if (!dct_valid) state_d = ST_ENDED;
            ST_ENDED: state_d = ST_ENDED;
            default:  state_d = ST_PACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_PACK;
            acc_q            <= '0;
            acc_cnt_q        <= '0;
            idle_q           <= '0;
            test_ending_q    <= 1'b0;
            test_has_ended_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            acc_cnt_q        <= acc_cnt_d;
            idle_q           <= idle_d;
            test_ending_q    <= (state_d == ST_FLUSH) || (state_d == ST_DRAIN);
            test_has_ended_q <= (state_d == ST_ENDED);
        end
    end

    mega_jsoc_oci_dct_out_reg u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_buf  (ld_buf),
        .load_cnt  (ld_cnt),
        .out_ready (dct_ready),
        .out_valid (dct_valid),
        .out_buf   (dct_buffer),
        .out_cnt   (dct_count),
        .out_free  (out_free)
    );

    assign test_ending    = test_ending_q;
    assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_mega_jsoc_cpu_oci_dct_packer.sv
// Directed bench for the DCT packer with a symbol-queue scoreboard for the
// randomized backpressure phase.
module tb_mega_jsoc_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frag_valid;
    logic        frag_ready;
    logic [5:0]  frag_data;
    logic [1:0]  frag_len;
    logic        end_req;
    logic        dct_valid;
    logic        dct_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;

    int checks   = 0;
    int failures = 0;
    bit sb_en    = 1'b0;
    logic [1:0] sbq[$];

    mega_jsoc_cpu_oci_dct_packer #(.IDLE_FLUSH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .frag_valid     (frag_valid),
        .frag_ready     (frag_ready),
        .frag_data      (frag_data),
        .frag_len       (frag_len),
        .end_req        (end_req),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge after inputs are driven; samples handshakes, then advances one cycle.
    task automatic tick();
        logic [29:0] exp_buf;
        bit          under;
        #1;
        if (sb_en) begin
            if (frag_valid && frag_ready)
                for (int i = 0; i < int'(frag_len); i++) sbq.push_back(frag_data[2*i +: 2]);
            if (dct_valid && dct_ready) begin
                exp_buf = '0;
                under   = 1'b0;
                for (int k = 0; k < int'(dct_count); k++) begin
                    if (sbq.size() == 0) under = 1'b1;
                    else exp_buf = exp_buf | (30'(sbq.pop_front()) << (2*k));
                end
                chk("sb_word", {1'b0, under, (dct_count != 4'd0), dct_buffer},
                               {2'b00, 1'b1, exp_buf});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [5:0] d, input logic [1:0] l);
        int n;
        frag_valid = 1'b1;
        frag_data  = d;
        frag_len   = l;
        n = 0;
        #1;
        while (!frag_ready && n < 200) begin
            tick();
            n++;
            #1;
        end
        if (!frag_ready) chk("send_timeout", 32'(frag_ready), 32'd1);
        tick();
        frag_valid = 1'b0;
        frag_data  = '0;
        frag_len   = '0;
    endtask

    initial begin
        int n;
        bit bad;
        reset = 1'b1; frag_valid = 1'b0; frag_data = '0; frag_len = '0;
        end_req = 1'b0; dct_ready = 1'b1;
        @(negedge clk);
        tick(); tick();
        chk("reset_state", {26'b0, frag_ready, dct_valid, dct_count, test_ending, test_has_ended}, 32'd0);
        chk("reset_buf", {2'b0, dct_buffer}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: five full fragments give one 15-slot word, one cycle after the 5th accept
        send(6'h24, 3); send(6'h13, 3); send(6'h0E, 3); send(6'h39, 3);
        chk("t1_no_early", 32'(dct_valid), 32'd0);
        send(6'h24, 3);
        chk("t1_word", {1'b0, dct_valid, dct_count, 26'b0}, {1'b0, 1'b1, 4'd15, 26'b0});
        chk("t1_buf", {2'b0, dct_buffer}, 32'h24E4E4E4);

        // 2: 13 slots packed with the output held; a len=3 fragment must wait
        dct_ready = 1'b0;
        send(6'h39, 3); send(6'h39, 3); send(6'h39, 3); send(6'h39, 3); send(6'h02, 1);
        frag_valid = 1'b1; frag_data = 6'h3F; frag_len = 2'd3;
        #1;
        chk("t2_blocked", 32'(frag_ready), 32'd0);
        tick(); tick();
        #1;
        chk("t2_still_blocked", 32'(frag_ready), 32'd0);
        chk("t2_held", {dct_valid, dct_count, dct_buffer[26:0]}, {1'b1, 4'd15, 27'h4E4E4E4});
        dct_ready = 1'b1;
        #1;
        chk("t2_ready", 32'(frag_ready), 32'd1);
        tick();
        frag_valid = 1'b0; frag_len = '0;
        chk("t2_word13", {1'b0, dct_valid, dct_count, 26'b0}, {1'b0, 1'b1, 4'd13, 26'b0});
        chk("t2_buf13", {2'b0, dct_buffer}, 32'h02E79E79);
        send(6'h00, 3); send(6'h00, 3); send(6'h00, 3);
        chk("t2_drained", 32'(dct_valid), 32'd0);
        send(6'h00, 3);
        chk("t2_carry", {dct_valid, dct_count, dct_buffer[26:0]}, {1'b1, 4'd15, 27'h3F});
        chk("t2_carry_hi", 32'(dct_buffer[29:27]), 32'd0);

        // 3: lone len=2 fragment is forced out exactly 64 cycles after accept
        send(6'h37, 2);
        bad = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (dct_valid) bad = 1'b1;
            tick();
        end
        chk("t3_no_early", 32'(bad), 32'd0);
        chk("t3_idle_word", {1'b0, dct_valid, dct_count, 26'b0}, {1'b0, 1'b1, 4'd2, 26'b0});
        chk("t3_buf", {2'b0, dct_buffer}, 32'h00000007);

        // 6: random traffic and backpressure against the symbol scoreboard
        tick();
        sb_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            frag_valid = ($urandom_range(3) != 0);
            frag_data  = 6'($urandom);
            frag_len   = 2'($urandom);
            dct_ready  = ($urandom_range(2) != 0);
            tick();
        end
        frag_valid = 1'b0; frag_len = '0; dct_ready = 1'b1;
        n = 0;
        while ((sbq.size() != 0 || dct_valid) && n < 300) begin
            tick();
            n++;
        end
        chk("t6_sb_empty", {30'b0, (sbq.size() == 0), dct_valid}, 32'd2);
        sb_en = 1'b0;

        // 5: mid-operation reset with a held word and 7 slots packed
        dct_ready = 1'b0;
        repeat (5) send(6'h3F, 3);
        chk("t5_held", 32'(dct_valid), 32'd1);
        send(6'h3F, 3); send(6'h3F, 3); send(6'h3F, 1);
        reset = 1'b1;
        tick();
        chk("t5_reset_outs", {26'b0, frag_ready, dct_valid, dct_count, test_ending, test_has_ended}, 32'd0);
        chk("t5_reset_buf", {2'b0, dct_buffer}, 32'd0);
        reset = 1'b0; dct_ready = 1'b1;
        send(6'h39, 3);
        repeat (4) send(6'h00, 3);
        chk("t5_slot0", {dct_valid, dct_count, dct_buffer[26:0]}, {1'b1, 4'd15, 27'h39});

        // 4: end_req together with an accepted fragment; partial word then ENDED
        send(6'h1B, 3); send(6'h02, 1);
        frag_valid = 1'b1; frag_data = 6'h01; frag_len = 2'd1; end_req = 1'b1;
        #1;
        chk("t4_accept", 32'(frag_ready), 32'd1);
        tick();
        frag_valid = 1'b0; frag_len = '0; end_req = 1'b0; dct_ready = 1'b0;
        #1;
        chk("t4_flush", {28'b0, test_ending, test_has_ended, dct_valid, frag_ready}, 32'b1000);
        tick();
        chk("t4_word", {dct_valid, dct_count, dct_buffer[26:0]}, {1'b1, 4'd5, 27'h19B});
        chk("t4_ending", {30'b0, test_ending, test_has_ended}, 32'b10);
        tick(); tick();
        chk("t4_drain_hold", {29'b0, dct_valid, test_ending, test_has_ended}, 32'b110);
        dct_ready = 1'b1;
        tick();
        chk("t4_taken", {29'b0, dct_valid, test_ending, test_has_ended}, 32'b010);
        tick();
        chk("t4_ended", {30'b0, test_ending, test_has_ended}, 32'b01);
        end_req = 1'b1; frag_valid = 1'b1; frag_len = 2'd3;
        #1;
        chk("t4_ended_noready", 32'(frag_ready), 32'd0);
        tick();
        end_req = 1'b0; frag_valid = 1'b0; frag_len = '0;
        chk("t4_sticky", {30'b0, test_ending, test_has_ended}, 32'b01);

        // 7: end_req with everything empty reaches ENDED two cycles later
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_cleared", 32'(test_has_ended), 32'd0);
        end_req = 1'b1;
        tick();
        end_req = 1'b0;
        tick();
        chk("t7_drain", {30'b0, test_ending, test_has_ended}, 32'b10);
        tick();
        chk("t7_ended", {30'b0, test_ending, test_has_ended}, 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
